mmio_timer: RTL and testbench

Memory-mapped down-counting timer that acts as the responder on the CPU's data-memory store/load port. It is decoded by the system bridge alongside DM. It answers single-cycle word reads and writes from the M stage and raises an interrupt line toward the CPU when the count expires. Two timer modes are supported: one-shot and auto-reload.

---
 rtl/mmio_timer_pkg.sv | 25 ++
 rtl/mmio_timer.sv | 135 +++++++++++++
 tb/tb_mmio_timer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mmio_timer_pkg.sv
// Shared constants for the memory-mapped down-counting timer.
package mmio_timer_pkg;

  // Register word offsets (A[3:2])
  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;

  // CTRL bit indices; MODE occupies [TC_MODE +: 2]
  localparam int unsigned TC_EN     = 0;
  localparam int unsigned TC_MODE   = 1;
  localparam int unsigned TC_IM     = 3;
  localparam int unsigned TC_CTRL_W = 4;

  // Only auto-reload is distinguished; every other code behaves as one-shot
  localparam logic [1:0] TC_MODE_RELOAD = 2'b01;

  typedef enum logic [1:0] {
    TC_IDLE = 2'b00,
    TC_LOAD = 2'b01,
    TC_CNT  = 2'b10,
    TC_INT  = 2'b11
  } tc_state_e;

endpackage

// File: rtl/mmio_timer.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes.
// Single-cycle word reads/writes from the M stage; registered interrupt output.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [TC_CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [WIDTH-1:0]     preset_q, preset_d;
  logic [WIDTH-1:0]     count_q, count_d;
  tc_state_e            state_q, state_d;
  logic                 pend_q, pend_d;
  logic                 irq_q;

  logic wr_ctrl, wr_preset, en_eff;

  assign wr_ctrl   = sel & we & (addr == TC_CTRL);
  assign wr_preset = sel & we & (addr == TC_PRESET);
  // A CTRL write steers the FSM on the same edge it lands
  assign en_eff    = wr_ctrl ? wdata[TC_EN] : ctrl_q[TC_EN];

  // Next-state: FSM update first, CPU writes override afterwards so they win collisions
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    pend_d   = pend_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;

    unique case (state_q)
      TC_IDLE: begin
        if (en_eff) state_d = TC_LOAD;
      end
      TC_LOAD: begin
        if (en_eff) begin
          count_d = preset_q;
          state_d = TC_CNT;
        end else begin
          state_d = TC_IDLE;
        end
      end
      TC_CNT: begin
        if (!en_eff) begin
          state_d = TC_IDLE;
        end else if (count_q > WIDTH'(1)) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          count_d = '0;
          pend_d  = 1'b1;
          state_d = TC_INT;
        end
      end
      TC_INT: begin
        state_d = TC_IDLE;
        if (ctrl_q[TC_MODE +: 2] == TC_MODE_RELOAD) begin
          pend_d = 1'b0;
        end else begin
          ctrl_d[TC_EN] = 1'b0;
        end
      end
      default: state_d = TC_IDLE;
    endcase

    if (wr_ctrl) begin
      ctrl_d = wdata[TC_CTRL_W-1:0];
      pend_d = 1'b0;
    end
    if (wr_preset) begin
      preset_d = wdata[WIDTH-1:0];
      pend_d   = 1'b0;
    end
  end

  // State and register file
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= TC_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

  // Interrupt is registered off the stored pending flag and mask
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= pend_q & ctrl_q[TC_IM];
    end
  end

  assign irq = irq_q;

  logic [31:0] preset_ext, count_ext;

  // Zero-extend narrow registers for readback
  always_comb begin
    preset_ext             = '0;
    count_ext              = '0;
    preset_ext[WIDTH-1:0]  = preset_q;
    count_ext[WIDTH-1:0]   = count_q;
  end

  // Combinational read mux; zero when deselected or reserved offset
  always_comb begin
    rdata = '0;
    if (sel) begin
      unique case (addr)
        TC_CTRL:   rdata = {{(32 - TC_CTRL_W){1'b0}}, ctrl_q};
        TC_PRESET: rdata = preset_ext;
        TC_COUNT:  rdata = count_ext;
        default:   rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed self-checking bench for mmio_timer.
module tb_mmio_timer;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;
  localparam logic [1:0] A_RSVD   = 2'd3;

  logic        clk;
  logic        reset;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_assert;
  int n_fail;

  mmio_timer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Write lands on the next rising edge; returns 1ns after that edge
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    sel   = 1'b1;
    we    = 1'b1;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    sel   = 1'b0;
    we    = 1'b0;
    wdata = '0;
  endtask

  // Combinational read, consumes 1ns, no edge
  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    sel  = 1'b1;
    we   = 1'b0;
    addr = a;
    #1;
    d    = rdata;
    sel  = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] v;
  logic [31:0] exp_cnt [7];
  logic        exp_irq [7];

  initial begin
    n_assert = 0;
    n_fail   = 0;
    sel = 1'b0; we = 1'b0; addr = '0; wdata = '0; reset = 1'b0;
    do_reset();

    // Reset values
    rd(A_CTRL, v);   check_eq("rst_ctrl", v, 32'h0);
    rd(A_PRESET, v); check_eq("rst_preset", v, 32'h0);
    rd(A_COUNT, v);  check_eq("rst_count", v, 32'h0);
    check_eq("rst_irq", {31'b0, irq}, 32'h0);

    // Register access: unused CTRL bits, COUNT/reserved writes ignored, deselect reads 0
    wr(A_CTRL, 32'hFFFF_FFF8);
    rd(A_CTRL, v);   check_eq("ctrl_mask", v, 32'h8);
    wr(A_COUNT, 32'h55);
    wr(A_RSVD, 32'h77);
    rd(A_COUNT, v);  check_eq("count_ro", v, 32'h0);
    rd(A_RSVD, v);   check_eq("rsvd_rd", v, 32'h0);
    wr(A_PRESET, 32'hDEAD_BEEF);
    rd(A_PRESET, v); check_eq("preset_rw", v, 32'hDEAD_BEEF);
    sel = 1'b0; addr = A_PRESET; #1;
    check_eq("desel_rd", rdata, 32'h0);
    do_reset();

    // One-shot, P=5, EN at e0: COUNT 5..1 after e1..e5, 0 after e6, irq after e7
    exp_cnt = '{32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
    exp_irq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    wr(A_PRESET, 32'd5);
    wr(A_CTRL, 32'h9);
    for (int k = 0; k < 7; k++) begin
      step(1);
      rd(A_COUNT, v);
      check_eq($sformatf("os_count_e%0d", k + 1), v, exp_cnt[k]);
      check_eq($sformatf("os_irq_e%0d", k + 1), {31'b0, irq}, {31'b0, exp_irq[k]});
    end
    rd(A_CTRL, v); check_eq("os_ctrl_en_cleared", v, 32'h8);
    step(3);
    check_eq("os_irq_held", {31'b0, irq}, 32'h1);
    wr(A_CTRL, 32'h8);
    check_eq("os_irq_clr_lag", {31'b0, irq}, 32'h1);
    step(1);
    check_eq("os_irq_clr", {31'b0, irq}, 32'h0);

    // Auto-reload, P=2: period 5, irq high after e4, e9, e14
    do_reset();
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'hB);
    for (int k = 1; k <= 15; k++) begin
      step(1);
      check_eq($sformatf("ar_irq_e%0d", k), {31'b0, irq}, (k % 5 == 4) ? 32'h1 : 32'h0);
    end
    rd(A_CTRL, v); check_eq("ar_ctrl_en_kept", v, 32'hB);
    wr(A_CTRL, 32'h0);

    // Disable mid-count at COUNT=6, then re-enable reloads
    do_reset();
    wr(A_PRESET, 32'd10);
    wr(A_CTRL, 32'h9);
    step(5);
    rd(A_COUNT, v); check_eq("dis_count6", v, 32'd6);
    wr(A_CTRL, 32'h8);
    rd(A_COUNT, v); check_eq("dis_hold_a", v, 32'd6);
    step(3);
    rd(A_COUNT, v); check_eq("dis_hold_b", v, 32'd6);
    check_eq("dis_irq", {31'b0, irq}, 32'h0);
    wr(A_CTRL, 32'h9);
    step(1);
    rd(A_COUNT, v); check_eq("dis_reload", v, 32'd10);
    wr(A_CTRL, 32'h0);

    // P=0 with IM=1 matches P=1 timing: irq after e3, not e2
    for (int p = 0; p < 2; p++) begin
      do_reset();
      wr(A_PRESET, p);
      wr(A_CTRL, 32'h9);
      step(2);
      check_eq($sformatf("p%0d_irq_e2", p), {31'b0, irq}, 32'h0);
      step(1);
      check_eq($sformatf("p%0d_irq_e3", p), {31'b0, irq}, 32'h1);
    end

    // P=0 with IM=0: reaches INT, irq stays 0, CTRL write keeps it 0
    do_reset();
    wr(A_CTRL, 32'h1);
    step(3);
    rd(A_COUNT, v); check_eq("p0m_count", v, 32'h0);
    rd(A_CTRL, v);  check_eq("p0m_ctrl", v, 32'h0);
    check_eq("p0m_irq", {31'b0, irq}, 32'h0);
    wr(A_CTRL, 32'h8);
    step(2);
    check_eq("p0m_irq_after_im", {31'b0, irq}, 32'h0);

    // PRESET write on the edge CNT expires: write wins, no irq
    do_reset();
    wr(A_PRESET, 32'd3);
    wr(A_CTRL, 32'h9);
    step(3);
    rd(A_COUNT, v); check_eq("col_count1", v, 32'd1);
    wr(A_PRESET, 32'd7);
    rd(A_COUNT, v); check_eq("col_count0", v, 32'd0);
    step(2);
    check_eq("col_irq", {31'b0, irq}, 32'h0);
    step(1);
    check_eq("col_irq_late", {31'b0, irq}, 32'h0);
    rd(A_PRESET, v); check_eq("col_preset", v, 32'd7);
    rd(A_CTRL, v);   check_eq("col_ctrl", v, 32'h8);

    // Async reset mid-count clears immediately and does not restart
    do_reset();
    wr(A_PRESET, 32'd5);
    wr(A_CTRL, 32'h9);
    step(3);
    rd(A_COUNT, v); check_eq("ar_pre_count3", v, 32'd3);
    reset = 1'b1;
    #1;
    rd(A_COUNT, v);  check_eq("arst_count", v, 32'h0);
    rd(A_CTRL, v);   check_eq("arst_ctrl", v, 32'h0);
    rd(A_PRESET, v); check_eq("arst_preset", v, 32'h0);
    check_eq("arst_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    step(4);
    rd(A_COUNT, v); check_eq("arst_no_restart", v, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
